// File: rtl/dlsc_pcie_s6_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the Spartan-6 PCIe TX TLP stream
// among PORTS sources, with a yield path for the core's config completions.
module dlsc_pcie_s6_tx_arbiter #(
    parameter int PORTS   = 3,
    parameter int BUF_MIN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PORTS-1:0]     in_valid_i,
    output logic [PORTS-1:0]     in_ready_o,
    input  logic [32*PORTS-1:0]  in_data_i,
    input  logic [PORTS-1:0]     in_last_i,
    input  logic                 tx_ready_i,
    output logic                 tx_valid_o,
    output logic [31:0]          tx_data_o,
    output logic                 tx_last_o,
    input  logic [5:0]           tx_buf_av_i,
    input  logic                 tx_cfg_req_i,
    output logic                 tx_cfg_gnt_o,
    output logic [1:0]           dbg_state_o
);

    localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

    // Handshake: a word moves on any cycle with tx_valid_o && tx_ready_i;
    // tx_valid_o never looks at tx_ready_i, only in_ready_o does.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_CFG  = 2'd2
    } state_t;

    state_t         st_q, st_d;
    logic [GW-1:0]  grant_q, grant_d;
    logic [GW-1:0]  last_q, last_d;

    logic           arb_found;
    logic [GW-1:0]  arb_pick;
    logic [GW-1:0]  arb_cand;
    logic           sel_valid;
    logic           sel_last;
    logic [31:0]    sel_data;

    // Search upward from the port after the last winner, wrapping.
    always_comb begin
        arb_found = 1'b0;
        arb_pick  = '0;
        arb_cand  = last_q;
        for (int i = 0; i < PORTS; i++) begin
            arb_cand = (arb_cand == GW'(PORTS - 1)) ? '0 : arb_cand + 1'b1;
            if (!arb_found && in_valid_i[arb_cand]) begin
                arb_found = 1'b1;
                arb_pick  = arb_cand;
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int p = 0; p < PORTS; p++) begin
            if (grant_q == GW'(p)) begin
                sel_valid = in_valid_i[p];
                sel_last  = in_last_i[p];
                sel_data  = in_data_i[32*p +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            grant_q <= '0;
            last_q  <= GW'(PORTS - 1);
        end else begin
            st_q    <= st_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        st_d    = st_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (st_q)
            ST_IDLE: begin
                if (tx_cfg_req_i) begin
                    st_d = ST_CFG;
                end else if (arb_found && (tx_buf_av_i >= 6'(BUF_MIN))) begin
                    st_d    = ST_PKT;
                    grant_d = arb_pick;
                end
            end
            ST_PKT: begin
                // Only the final word ends a grant; bubbles keep the link.
                if (tx_ready_i && sel_valid && sel_last) begin
                    st_d   = ST_IDLE;
                    last_d = grant_q;
                end
            end
            ST_CFG: begin
                if (!tx_cfg_req_i) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_valid_o   = (st_q == ST_PKT) && sel_valid;
        tx_data_o    = sel_data;
        tx_last_o    = sel_last;
        tx_cfg_gnt_o = (st_q == ST_CFG);
        dbg_state_o  = st_q;
        in_ready_o   = '0;
        for (int p = 0; p < PORTS; p++) begin
            in_ready_o[p] = (st_q == ST_PKT) && (grant_q == GW'(p)) && tx_ready_i;
        end
    end

endmodule

// File: tb/tb_dlsc_pcie_s6_tx_arbiter.sv
// Directed bench for dlsc_pcie_s6_tx_arbiter (PORTS=3, BUF_MIN=2) with
// hand-computed expectations checked by immediate assertions.
module tb_dlsc_pcie_s6_tx_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   in_valid;
    logic [2:0]   in_ready;
    logic [95:0]  in_data;
    logic [2:0]   in_last;
    logic         tx_ready;
    logic         tx_valid;
    logic [31:0]  tx_data;
    logic         tx_last;
    logic [5:0]   tx_buf_av;
    logic         tx_cfg_req;
    logic         tx_cfg_gnt;
    logic [1:0]   dbg_state;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    dlsc_pcie_s6_tx_arbiter #(.PORTS(3), .BUF_MIN(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .in_last_i    (in_last),
        .tx_ready_i   (tx_ready),
        .tx_valid_o   (tx_valid),
        .tx_data_o    (tx_data),
        .tx_last_o    (tx_last),
        .tx_buf_av_i  (tx_buf_av),
        .tx_cfg_req_i (tx_cfg_req),
        .tx_cfg_gnt_o (tx_cfg_gnt),
        .dbg_state_o  (dbg_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic v, input logic [31:0] d, input logic l);
        in_valid[p]      = v;
        in_data[p*32 +: 32] = d;
        in_last[p]       = l;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        in_valid   = '0;
        in_data    = '0;
        in_last    = '0;
        tx_ready   = 1'b1;
        tx_buf_av  = 6'd10;
        tx_cfg_req = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [2:0] oh;
    int p;

    initial begin
        // Reset state
        do_reset();
        #1;
        chk("rst_valid", tx_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_gnt", tx_cfg_gnt, 0);
        chk("rst_state", dbg_state, 0);

        // Single 3-word packet from port 1
        set_port(1, 1, 32'hA0, 0);
        #1 chk("t1_idle_valid", tx_valid, 0);
        tick();
        chk("t1_w0_valid", tx_valid, 1);
        chk("t1_w0_data", tx_data, 32'hA0);
        chk("t1_w0_last", tx_last, 0);
        chk("t1_w0_ready", in_ready, 3'b010);
        tick();
        set_port(1, 1, 32'hA1, 0);
        #1 chk("t1_w1_data", tx_data, 32'hA1);
        chk("t1_w1_last", tx_last, 0);
        chk("t1_w1_ready", in_ready, 3'b010);
        tick();
        set_port(1, 1, 32'hA2, 1);
        #1 chk("t1_w2_data", tx_data, 32'hA2);
        chk("t1_w2_last", tx_last, 1);
        chk("t1_w2_ready", in_ready, 3'b010);
        tick();
        set_port(1, 0, 32'h0, 0);
        #1 chk("t1_end_valid", tx_valid, 0);
        chk("t1_end_state", dbg_state, 0);

        // All ports continuously valid, 2-word packets, round robin
        do_reset();
        for (int q = 0; q < 3; q++) set_port(q, 1, 32'hB000_0000 | (q << 8), 0);
        for (int k = 0; k < 6; k++) begin
            p  = k % 3;
            oh = 3'b001 << p;
            #1 chk("rr_idle_valid", tx_valid, 0);
            tick();
            chk("rr_w0_valid", tx_valid, 1);
            chk("rr_w0_data", tx_data, 32'hB000_0000 | (p << 8));
            chk("rr_w0_last", tx_last, 0);
            chk("rr_w0_ready", in_ready, oh);
            tick();
            set_port(p, 1, 32'hB000_0001 | (p << 8), 1);
            #1 chk("rr_w1_data", tx_data, 32'hB000_0001 | (p << 8));
            chk("rr_w1_last", tx_last, 1);
            chk("rr_w1_ready", in_ready, oh);
            tick();
            set_port(p, 1, 32'hB000_0000 | (p << 8), 0);
        end
        in_valid = '0;

        // Backpressure and source bubble while port 2 waits
        do_reset();
        set_port(0, 1, 32'hC0, 0);
        set_port(2, 1, 32'hD0, 1);
        tick();
        chk("bp_w0_data", tx_data, 32'hC0);
        chk("bp_w0_ready", in_ready, 3'b001);
        tick();
        set_port(0, 1, 32'hC1, 0);
        tx_ready = 1'b0;
        #1 chk("bp_stall_data", tx_data, 32'hC1);
        chk("bp_stall_valid", tx_valid, 1);
        chk("bp_stall_ready", in_ready, 3'b000);
        tick();
        tx_ready = 1'b1;
        #1 chk("bp_hold_data", tx_data, 32'hC1);
        chk("bp_hold_ready", in_ready, 3'b001);
        tick();
        set_port(0, 0, 32'hC2, 0);
        #1 chk("bp_bub1_valid", tx_valid, 0);
        chk("bp_bub1_ready", in_ready, 3'b001);
        chk("bp_bub1_state", dbg_state, 1);
        tick();
        chk("bp_bub2_valid", tx_valid, 0);
        chk("bp_bub2_ready", in_ready, 3'b001);
        tick();
        set_port(0, 1, 32'hC2, 1);
        #1 chk("bp_last_data", tx_data, 32'hC2);
        chk("bp_last_last", tx_last, 1);
        tick();
        set_port(0, 0, 32'h0, 0);
        #1 chk("bp_idle_valid", tx_valid, 0);
        tick();
        chk("bp_p2_data", tx_data, 32'hD0);
        chk("bp_p2_ready", in_ready, 3'b100);
        tick();
        set_port(2, 0, 32'h0, 0);

        // Config request mid-packet
        do_reset();
        set_port(0, 1, 32'hE0, 0);
        set_port(1, 1, 32'hF0, 1);
        tick();
        chk("cfg_w0_data", tx_data, 32'hE0);
        tick();
        set_port(0, 1, 32'hE1, 0);
        tx_cfg_req = 1'b1;
        #1 chk("cfg_w1_data", tx_data, 32'hE1);
        chk("cfg_w1_gnt", tx_cfg_gnt, 0);
        tick();
        set_port(0, 1, 32'hE2, 0);
        #1 chk("cfg_w2_data", tx_data, 32'hE2);
        chk("cfg_w2_gnt", tx_cfg_gnt, 0);
        tick();
        set_port(0, 1, 32'hE3, 1);
        #1 chk("cfg_w3_data", tx_data, 32'hE3);
        chk("cfg_w3_last", tx_last, 1);
        tick();
        set_port(0, 0, 32'h0, 0);
        #1 chk("cfg_idle_state", dbg_state, 0);
        chk("cfg_idle_gnt", tx_cfg_gnt, 0);
        tick();
        chk("cfg_gnt_hi", tx_cfg_gnt, 1);
        chk("cfg_gnt_valid", tx_valid, 0);
        chk("cfg_gnt_ready", in_ready, 3'b000);
        tick();
        chk("cfg_gnt_hold", tx_cfg_gnt, 1);
        tx_cfg_req = 1'b0;
        #1 chk("cfg_drop_gnt", tx_cfg_gnt, 1);
        tick();
        chk("cfg_gnt_lo", tx_cfg_gnt, 0);
        chk("cfg_resume_valid", tx_valid, 0);
        tick();
        chk("cfg_next_valid", tx_valid, 1);
        chk("cfg_next_data", tx_data, 32'hF0);
        chk("cfg_next_ready", in_ready, 3'b010);
        tick();
        set_port(1, 0, 32'h0, 0);

        // Buffer-space threshold
        do_reset();
        tx_buf_av = 6'd1;
        set_port(0, 1, 32'h60, 1);
        tick();
        chk("buf_low_valid", tx_valid, 0);
        chk("buf_low_state", dbg_state, 0);
        tick();
        chk("buf_low2_valid", tx_valid, 0);
        tx_buf_av = 6'd2;
        #1 chk("buf_raise_valid", tx_valid, 0);
        tick();
        tx_buf_av = 6'd0;
        #1 chk("buf_go_valid", tx_valid, 1);
        chk("buf_go_data", tx_data, 32'h60);
        tick();
        set_port(0, 0, 32'h0, 0);
        tx_buf_av = 6'd10;

        // Reset mid-packet: port 0 (last winner) must still win afterwards
        set_port(1, 1, 32'h70, 0);
        #1 chk("mid_idle_valid", tx_valid, 0);
        tick();
        chk("mid_w0_data", tx_data, 32'h70);
        tick();
        set_port(1, 1, 32'h71, 0);
        tick();
        set_port(1, 1, 32'h72, 0);
        #1 chk("mid_w2_data", tx_data, 32'h72);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_port(0, 1, 32'h80, 1);
        set_port(1, 1, 32'h90, 1);
        set_port(2, 1, 32'hA8, 1);
        #1 chk("mid_rst_valid", tx_valid, 0);
        chk("mid_rst_ready", in_ready, 3'b000);
        chk("mid_rst_gnt", tx_cfg_gnt, 0);
        tick();
        chk("mid_arb_data", tx_data, 32'h80);
        chk("mid_arb_ready", in_ready, 3'b001);
        tick();
        in_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/dlsc_pcie_s6_tx_arbiter.md
# dlsc_pcie_s6_tx_arbiter

Packet-level round-robin arbiter that shares the single 32-bit Spartan-6 PCIe transmit TLP stream among PORTS independent TLP sources, e.g. the inbound completion generator, the outbound request generator and the message generator. It never interleaves packets. It starts a packet only when the core reports enough transmit buffer space. It yields the link to the core's configuration-completion path through the tx_cfg_req/tx_cfg_gnt handshake. It sits between the TLP generators' output FIFOs and the core's trn_t* interface.

## Interface
- PORTS, 3: number of requesting TLP sources, 1..8.
- BUF_MIN, 2: minimum tx_buf_av required to start a new packet, 0..63.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  PORTS  per-port TLP word valid.
- in_ready  out  PORTS  per-port TLP word accept.
- in_data  in  32*PORTS  per-port TLP word; port p occupies bits [32p+31:32p].
- in_last  in  PORTS  per-port end-of-TLP marker.
- tx_ready  in  1  core accepts word.
- tx_valid  out  1  word valid to core.
- tx_data  out  32  word to core.
- tx_last  out  1  end-of-TLP to core.
- tx_buf_av  in  6  core transmit buffers available.
- tx_cfg_req  in  1  core requests the link for a config completion.
- tx_cfg_gnt  out  1  link yielded to the core.

## Operation
- State machine:
  - IDLE: no grant. tx_valid=0, all in_ready=0.
  - PKT: port g granted.
  - CFG: link yielded to the core. tx_cfg_gnt=1.
- IDLE transitions, evaluated each cycle:
  - tx_cfg_req=1 → CFG. Config requests take priority over pending packets.
  - else if any in_valid, and tx_buf_av >= BUF_MIN as an unsigned 6-bit compare → PKT. g becomes the first asserted in_valid searching upward from (last+1) mod PORTS, wrapping.
  - else stay in IDLE.
- PKT:
  - tx_valid=in_valid[g], tx_data=in_data[g], tx_last=in_last[g].
  - in_ready[g]=tx_ready; all other in_ready=0.
  - A word transfers when tx_ready && in_valid[g].
  - A transfer with in_last[g]=1 → IDLE and last<=g.
  - tx_cfg_req and tx_buf_av are ignored mid-packet. A packet is never aborted.
- CFG: stays while tx_cfg_req=1. tx_cfg_req=0 → IDLE.
- Round-robin fairness: once a port completes a packet, it is the lowest priority at the next arbitration. A port with continuous valid waits at most PORTS-1 packets.
- Grant is held for the whole packet even when in_valid[g] drops mid-packet, i.e. a bubble from the source. No other port may use the link during the bubble.
- Valid/ready rules:
  - tx_valid must not depend on tx_ready.
  - The outputs are a combinational mux of the granted port, gated by registered state.
  - Data and last pass through unmodified.
- PORTS=1: the round-robin degenerates and g is always 0.
- Reset, applied at the next clk edge from any state including mid-packet:
  - st=IDLE, last=PORTS-1, so port 0 wins first, and tx_cfg_gnt=0.
  - tx_valid=0, tx_data and tx_last don't-care while tx_valid=0, in_ready=0.
  - A partially sent packet is abandoned; sources and core are reset together.

## Timing
- Arbitration costs one cycle: a request seen in IDLE at cycle n puts the first word on tx_* at cycle n+1.
- Within a packet, throughput is one word per cycle with zero added latency: in_* to tx_* is combinational.
- After tx_last is accepted at cycle n, st=IDLE at n+1, so the earliest next packet's first word appears at n+2.
- tx_cfg_gnt is registered:
  - req high in IDLE at cycle n → gnt high at n+1.
  - req dropped at cycle m → gnt low at m+1; arbitration resumes at m+1 with the next word at m+2.
- tx_cfg_req rising mid-packet: gnt is asserted one cycle after the IDLE cycle that follows tx_last.
- tx_buf_av is sampled only in IDLE. A later drop of tx_buf_av does not stall an in-flight packet.

## Test plan
- Reset, then port 1 sends a 3-word TLP (0xA0,0xA1,0xA2 with last on 0xA2) with tx_ready=1 and tx_buf_av=10:
  - words appear on cycles 1–3 after request with tx_last only on 0xA2.
  - in_ready[0,2]=0 throughout.
- All 3 ports continuously valid with 2-word packets:
  - grant order 0,1,2,0,1,2.
  - no interleaving.
  - each packet followed by exactly one idle cycle.
- Port 0 mid-packet, tx_ready toggling 1,0,1 and in_valid[0] bubble for 2 cycles while port 2 is valid:
  - tx_* holds the port 0 word during tx_ready=0.
  - port 2 is not granted until port 0's last word is accepted.
- tx_cfg_req asserted in the 2nd word of a 4-word packet:
  - packet completes intact, then tx_cfg_gnt rises.
  - while gnt=1 with ports valid, tx_valid stays 0.
  - after req drops, gnt falls the next cycle and the next packet starts one cycle later.
- tx_buf_av=1 with BUF_MIN=2 and port 0 valid: no grant, tx_valid=0. Raising tx_buf_av to 2 yields the first word one cycle later.
- rst asserted during the 3rd word of a 5-word packet: next cycle tx_valid=0, in_ready=0, tx_cfg_gnt=0. The next arbitration starts at port 0.
